// File: rtl/uart_rx_if.sv
// Receive-side bundle for the UART link: serial line in,
// received byte and status strobes out.
interface uart_rx_if;
    logic       rx;
    logic [7:0] data;
    logic       valid;
    logic       framing_error;
    logic       busy;

    modport master (
        output rx,
        input  data,
        input  valid,
        input  framing_error,
        input  busy
    );

    modport slave (
        input  rx,
        output data,
        output valid,
        output framing_error,
        output busy
    );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, start-glitch reject,
// stop-bit check, byte held between frames.
module uart_rx #(
    parameter int CLKS_PER_BIT = 5208
) (
    input logic      CLOCK_50,
    input logic      reset,
    uart_rx_if.slave bus
);
    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] MID  = CW'(HALF - 1);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    idx, idx_n;
    logic [7:0]    shreg, shreg_n;
    logic [7:0]    data_q, data_n;
    logic          valid_q, valid_n;
    logic          ferr_q, ferr_n;
    logic          rx_m, rx_s;

    // Idle-high line: reset the synchroniser to 1 so no false start.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= bus.rx;
            rx_s <= rx_m;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            idx     <= '0;
            shreg   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            idx     <= idx_n;
            shreg   <= shreg_n;
            data_q  <= data_n;
            valid_q <= valid_n;
            ferr_q  <= ferr_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        shreg_n = shreg;
        data_n  = data_q;
        valid_n = 1'b0;
        ferr_n  = 1'b0;
        unique case (state)
            IDLE: begin
                cnt_n = '0;
                if (!rx_s) state_n = START;
            end
            START: begin
                if (cnt == MID) begin
                    cnt_n   = '0;
                    idx_n   = '0;
                    state_n = rx_s ? IDLE : DATA;
                end else begin
                    cnt_n = cnt + ONE;
                end
            end
            DATA: begin
                if (cnt == LAST) begin
                    shreg_n = {rx_s, shreg[7:1]};
                    cnt_n   = '0;
                    idx_n   = idx + 3'd1;
                    if (idx == 3'd7) state_n = STOP;
                end else begin
                    cnt_n = cnt + ONE;
                end
            end
            STOP: begin
                if (cnt == LAST) begin
                    cnt_n   = '0;
                    state_n = IDLE;
                    if (rx_s) begin
                        data_n  = shreg;
                        valid_n = 1'b1;
                    end else begin
                        ferr_n = 1'b1;
                    end
                end else begin
                    cnt_n = cnt + ONE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.data          = data_q;
    assign bus.valid         = valid_q;
    assign bus.framing_error = ferr_q;
    assign bus.busy          = (state != IDLE);
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit.
// Expected bytes and latencies are worked out by hand.
module tb_uart_rx;
    localparam int CPB = 16;

    logic CLOCK_50 = 1'b0;
    logic reset    = 1'b1;
    int   cyc      = 0;
    int   checks   = 0;
    int   failures = 0;

    uart_rx_if bus ();

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .CLOCK_50(CLOCK_50),
        .reset   (reset),
        .bus     (bus)
    );

    always #5 CLOCK_50 = ~CLOCK_50;
    always @(posedge CLOCK_50) cyc <= cyc + 1;

    logic [7:0] vq[$];
    int         vt[$];
    int         fcnt = 0;
    int         both = 0;

    always @(negedge CLOCK_50) begin
        if (bus.valid) begin
            vq.push_back(bus.data);
            vt.push_back(cyc);
        end
        if (bus.framing_error) fcnt++;
        if (bus.valid && bus.framing_error) both++;
    end

    task automatic check(string tag, logic [31:0] got,
                         logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(int n);
        repeat (n) @(posedge CLOCK_50);
        #1;
    endtask

    task automatic drive_bit(logic v);
        bus.rx = v;
        tick(CPB);
    endtask

    task automatic send(logic [7:0] b, logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop);
    endtask

    task automatic clear_log();
        vq.delete();
        vt.delete();
        fcnt = 0;
    endtask

    function automatic logic [7:0] vq_at(int i);
        if (i < vq.size()) return vq[i];
        return 8'hxx;
    endfunction

    function automatic int vt_at(int i);
        if (i < vt.size()) return vt[i];
        return -1000;
    endfunction

    initial begin
        int       c0;
        int       d;
        logic     seen;
        logic     saw_busy;

        // reset and idle
        bus.rx = 1'b1;
        reset  = 1'b1;
        tick(3);
        reset = 1'b0;
        @(negedge CLOCK_50);
        check("rst_data", bus.data, 8'h00);
        check("rst_valid", bus.valid, 0);
        check("rst_ferr", bus.framing_error, 0);
        check("rst_busy", bus.busy, 0);
        seen = 1'b0;
        repeat (200) begin
            @(negedge CLOCK_50);
            if (bus.valid || bus.framing_error || bus.busy
                || bus.data != 8'h00) seen = 1'b1;
        end
        check("idle_quiet", seen, 0);
        tick(1);

        // single frame 0xA5
        clear_log();
        c0 = cyc;
        send(8'hA5, 1'b1);
        tick(20);
        check("a5_count", vq.size(), 1);
        check("a5_data", vq_at(0), 8'hA5);
        d = vt_at(0) - c0;
        check("a5_latency", (d >= 154 && d <= 156), 1);
        tick(100);
        check("a5_hold", bus.data, 8'hA5);

        // start-bit glitch
        clear_log();
        bus.rx = 1'b0;
        tick(4);
        bus.rx = 1'b1;
        saw_busy = 1'b0;
        repeat (10) begin
            @(negedge CLOCK_50);
            if (bus.busy) saw_busy = 1'b1;
        end
        check("gl_busy_seen", saw_busy, 1);
        check("gl_busy_fell", bus.busy, 0);
        tick(40);
        check("gl_valid", vq.size(), 0);
        check("gl_ferr", fcnt, 0);
        check("gl_data", bus.data, 8'hA5);

        // good frame then bad stop bit
        clear_log();
        send(8'h3C, 1'b1);
        tick(20);
        send(8'h81, 1'b0);
        bus.rx = 1'b1;
        tick(20);
        check("fe_count", vq.size(), 1);
        check("fe_first", vq_at(0), 8'h3C);
        check("fe_pulses", fcnt, 1);
        check("fe_data", bus.data, 8'h3C);

        // back-to-back frames
        clear_log();
        send(8'h00, 1'b1);
        send(8'hFF, 1'b1);
        tick(20);
        check("bb_count", vq.size(), 2);
        check("bb_first", vq_at(0), 8'h00);
        check("bb_second", vq_at(1), 8'hFF);
        d = vt_at(1) - vt_at(0);
        check("bb_gap", (d >= 159 && d <= 161), 1);

        // reset during bit 4 of 0x55
        clear_log();
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(i[0] ? 1'b0 : 1'b1);
        bus.rx = 1'b1;
        tick(CPB / 2);
        reset = 1'b1;
        tick(3);
        reset = 1'b0;
        tick(60);
        check("mr_valid", vq.size(), 0);
        check("mr_ferr", fcnt, 0);
        check("mr_data", bus.data, 8'h00);
        check("mr_busy", bus.busy, 0);
        send(8'h12, 1'b1);
        tick(20);
        check("mr_count", vq.size(), 1);
        check("mr_new", vq_at(0), 8'h12);
        check("mr_hold", bus.data, 8'h12);

        check("excl", both, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
